// File: rtl/reg_wb_port_if.sv
// Bundle of the writeback-port signals: pipeline writeback, multi-cycle result
// handshake, register-file write outputs and the hazard query lines.
interface reg_wb_port_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_we;
  logic [4:0]    wb_wa;
  logic [31:0]   wb_wd;

  logic          mdu_issue;
  logic [4:0]    mdu_issue_wa;

  // Result handshake: a transfer happens on a rising edge where mdu_valid and
  // mdu_ready are both high. mdu_ready never depends on mdu_valid.
  logic          mdu_valid;
  logic [4:0]    mdu_wa;
  logic [31:0]   mdu_wd;
  logic          mdu_ready;

  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;

  logic [4:0]    q_ra1;
  logic [4:0]    q_ra2;
  logic          q_busy1;
  logic          q_busy2;
  logic [CW-1:0] q_count;

  modport master (
    output wb_we, wb_wa, wb_wd,
    output mdu_issue, mdu_issue_wa,
    output mdu_valid, mdu_wa, mdu_wd,
    input  mdu_ready,
    input  rf_we, rf_wa, rf_wd,
    output q_ra1, q_ra2,
    input  q_busy1, q_busy2, q_count
  );

  modport slave (
    input  wb_we, wb_wa, wb_wd,
    input  mdu_issue, mdu_issue_wa,
    input  mdu_valid, mdu_wa, mdu_wd,
    output mdu_ready,
    output rf_we, rf_wa, rf_wd,
    input  q_ra1, q_ra2,
    output q_busy1, q_busy2, q_count
  );
endinterface

// File: rtl/reg_wb_port.sv
// Single register-file write port shared by the pipeline writeback and a queue
// of multi-cycle-unit results; also tracks registers with outstanding writes.
module reg_wb_port #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_wb_port_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    wa_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;

  logic          rf_we_q;
  logic [4:0]    rf_wa_q;
  logic [31:0]   rf_wd_q;

  logic          ready;
  logic          xfer;
  logic          push;
  logic          pipe_wr;
  logic          pop;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;

  assign ready   = !rst && (count < CW'(DEPTH));
  assign xfer    = bus.mdu_valid && ready;
  // Results for r0 are accepted so the unit is never stalled, then dropped.
  assign push    = xfer && (bus.mdu_wa != 5'd0);
  assign pipe_wr = bus.wb_we && (bus.wb_wa != 5'd0);
  assign pop     = !pipe_wr && (count != '0);
  assign head_wa = wa_mem[rd_ptr];
  assign head_wd = wd_mem[rd_ptr];

  // Set beats clear so a re-issue to the register being drained stays tracked.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_wa] = 1'b0;
    if (bus.mdu_issue && (bus.mdu_issue_wa != 5'd0)) pending_nxt[bus.mdu_issue_wa] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr] <= bus.mdu_wa;
      wd_mem[wr_ptr] <= bus.mdu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else if (pipe_wr) begin
      rf_we_q <= 1'b1;
      rf_wa_q <= bus.wb_wa;
      rf_wd_q <= bus.wb_wd;
    end else if (pop) begin
      rf_we_q <= 1'b1;
      rf_wa_q <= head_wa;
      rf_wd_q <= head_wd;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  // A write sitting on rf_* has left the queue but is not yet in the file.
  assign bus.q_busy1 = (bus.q_ra1 != 5'd0) &&
                       (pending[bus.q_ra1] || (rf_we_q && (rf_wa_q == bus.q_ra1)));
  assign bus.q_busy2 = (bus.q_ra2 != 5'd0) &&
                       (pending[bus.q_ra2] || (rf_we_q && (rf_wa_q == bus.q_ra2)));

  assign bus.mdu_ready = ready;
  assign bus.q_count   = count;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_wa_q;
  assign bus.rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_reg_wb_port.sv
// Directed bench for reg_wb_port: expected register-file writes go into a
// queue, a negedge monitor pops and compares every rf_we pulse.
module tb_reg_wb_port;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [36:0] exp_q[$];

  reg_wb_port_if #(.DEPTH(2)) bus ();

  reg_wb_port #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
    exp_q.push_back({wa, wd});
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_wa = wa;
    bus.wb_wd = wd;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.mdu_valid = v;
    bus.mdu_wa    = wa;
    bus.mdu_wd    = wd;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] wa);
    bus.mdu_issue    = v;
    bus.mdu_issue_wa = wa;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [36:0] exp_e;
    if (bus.rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got wa=%0d wd=%0h expected no write",
                 bus.rf_wa, bus.rf_wd);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.rf_wa, bus.rf_wd} !== exp_e) begin
          errors++;
          $display("FAIL rf_write: got wa=%0d wd=%0h expected wa=%0d wd=%0h",
                   bus.rf_wa, bus.rf_wd, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    drive_issue(1'b0, 5'd0);
    bus.q_ra1 = 5'd0;
    bus.q_ra2 = 5'd0;
    tick();
    tick();
    chk("reset_rf_we", bus.rf_we, 0);
    chk("reset_rf_wa", bus.rf_wa, 0);
    chk("reset_rf_wd", bus.rf_wd, 0);
    chk("reset_q_count", bus.q_count, 0);
    chk("reset_mdu_ready", bus.mdu_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", bus.mdu_ready, 1);

    // single pipeline write
    drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    chk("wb_rf_we", bus.rf_we, 1);
    chk("wb_rf_wa", bus.rf_wa, 5);
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("wb_rf_we_drop", bus.rf_we, 0);

    // issue then result, hazard tracking on r9
    bus.q_ra1 = 5'd9;
    bus.q_ra2 = 5'd0;
    drive_issue(1'b1, 5'd9);
    #1;
    chk("busy_before_issue", bus.q_busy1, 0);
    tick();
    drive_issue(1'b0, 5'd0);
    chk("busy_after_issue", bus.q_busy1, 1);
    chk("busy_r0_query", bus.q_busy2, 0);
    tick();
    tick();
    chk("busy_waiting", bus.q_busy1, 1);
    drive_mdu(1'b1, 5'd9, 32'h1234);
    chk("ready_empty", bus.mdu_ready, 1);
    expect_wr(5'd9, 32'h1234);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    bus.q_ra2 = 5'd9;
    #1;
    chk("count_after_push", bus.q_count, 1);
    chk("no_write_at_push", bus.rf_we, 0);
    chk("busy_queued", bus.q_busy1, 1);
    chk("busy_queued_port2", bus.q_busy2, 1);
    tick();
    chk("pop_rf_wd", bus.rf_wd, 32'h1234);
    chk("count_after_pop", bus.q_count, 0);
    chk("busy_on_rf", bus.q_busy1, 1);
    tick();
    chk("busy_cleared", bus.q_busy1, 0);
    bus.q_ra2 = 5'd0;

    // two results queued behind a continuous pipeline write to r7
    drive_wb(1'b1, 5'd7, 32'h70);
    drive_mdu(1'b1, 5'd3, 32'h3333);
    expect_wr(5'd7, 32'h70);
    tick();
    drive_wb(1'b1, 5'd7, 32'h71);
    drive_mdu(1'b1, 5'd4, 32'h4444);
    expect_wr(5'd7, 32'h71);
    tick();
    chk("full_count", bus.q_count, 2);
    chk("full_ready", bus.mdu_ready, 0);
    drive_wb(1'b1, 5'd7, 32'h72);
    drive_mdu(1'b1, 5'd5, 32'h5555);
    expect_wr(5'd7, 32'h72);
    tick();
    chk("full_hold_count", bus.q_count, 2);
    chk("starved_rf_wa", bus.rf_wa, 7);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'h3333);
    tick();
    chk("drain_first_wa", bus.rf_wa, 3);
    chk("drain_first_count", bus.q_count, 1);
    expect_wr(5'd4, 32'h4444);
    tick();
    chk("drain_second_wa", bus.rf_wa, 4);
    tick();
    chk("drain_done_we", bus.rf_we, 0);
    chk("drain_done_count", bus.q_count, 0);

    // r0 writes on both paths are no-ops; queue drains under wb_wa=0
    drive_wb(1'b1, 5'd7, 32'h700);
    drive_mdu(1'b1, 5'd8, 32'h88);
    expect_wr(5'd7, 32'h700);
    tick();
    chk("r0_setup_count", bus.q_count, 1);
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    drive_mdu(1'b1, 5'd0, 32'hEEEE);
    expect_wr(5'd8, 32'h88);
    tick();
    chk("r0_count", bus.q_count, 0);
    chk("r0_drain_wa", bus.rf_wa, 8);
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    drive_mdu(1'b1, 5'd0, 32'hEEEE);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    chk("r0_rf_we", bus.rf_we, 0);
    chk("r0_count_idle", bus.q_count, 0);
    chk("hold_rf_wa", bus.rf_wa, 8);
    chk("hold_rf_wd", bus.rf_wd, 32'h88);

    // re-issue to r6 in the same edge that pops r6
    bus.q_ra1 = 5'd6;
    drive_issue(1'b1, 5'd6);
    tick();
    drive_issue(1'b0, 5'd0);
    drive_mdu(1'b1, 5'd6, 32'h66);
    expect_wr(5'd6, 32'h66);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    drive_issue(1'b1, 5'd6);
    tick();
    drive_issue(1'b0, 5'd0);
    chk("reissue_rf_wa", bus.rf_wa, 6);
    tick();
    chk("reissue_rf_we", bus.rf_we, 0);
    chk("reissue_busy", bus.q_busy1, 1);
    drive_mdu(1'b1, 5'd6, 32'h67);
    expect_wr(5'd6, 32'h67);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk("reissue_busy_cleared", bus.q_busy1, 0);

    // reset with two entries queued
    bus.q_ra1 = 5'd10;
    bus.q_ra2 = 5'd11;
    drive_wb(1'b1, 5'd7, 32'h90);
    drive_mdu(1'b1, 5'd10, 32'hA0);
    drive_issue(1'b1, 5'd10);
    expect_wr(5'd7, 32'h90);
    tick();
    drive_issue(1'b0, 5'd0);
    drive_wb(1'b1, 5'd7, 32'h91);
    drive_mdu(1'b1, 5'd11, 32'hB0);
    expect_wr(5'd7, 32'h91);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    chk("prereset_count", bus.q_count, 2);
    chk("prereset_busy", bus.q_busy1, 1);
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b1, 5'd12, 32'hC0);
    #1;
    chk("rst_ready_low", bus.mdu_ready, 0);
    tick();
    chk("rst_count", bus.q_count, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_wa", bus.rf_wa, 0);
    chk("rst_rf_wd", bus.rf_wd, 0);
    chk("rst_busy1", bus.q_busy1, 0);
    chk("rst_busy2", bus.q_busy2, 0);
    tick();
    rst = 1'b0;
    drive_mdu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_rf_we", bus.rf_we, 0);
      chk("post_rst_count", bus.q_count, 0);
    end

    @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_port.md
REG_WB_PORT -- requirements
Module: reg_wb_port

Interface
REQ-001 Parameter DEPTH, default 2, number of queued multi-cycle-unit results (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 wb_we  input  1  pipeline writeback request, highest priority, no backpressure.
REQ-005 wb_wa  input  5  pipeline writeback destination register.
REQ-006 wb_wd  input  32  pipeline writeback data.
REQ-007 mdu_issue  input  1  multi-cycle unit accepted an instruction this cycle.
REQ-008 mdu_issue_wa  input  5  destination register of that instruction.
REQ-009 mdu_valid  input  1  multi-cycle result offered.
REQ-010 mdu_wa  input  5  result destination register.
REQ-011 mdu_wd  input  32  result data.
REQ-012 mdu_ready  output  1  result queue can accept; a transfer occurs when mdu_valid and mdu_ready are both high.
REQ-013 rf_we  output  1  register-file write enable, registered.
REQ-014 rf_wa  output  5  register-file write address, registered.
REQ-015 rf_wd  output  32  register-file write data, registered.
REQ-016 q_ra1, q_ra2  input  5 each  hazard-unit query addresses.
REQ-017 q_busy1, q_busy2  output  1 each  queried register has an outstanding write, combinational.
REQ-018 q_count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-019 The block SHALL hold a FIFO of DEPTH {wa, wd} entries, a 32-bit pending vector, and the registered rf_* outputs.
REQ-020 mdu_ready SHALL be high when q_count < DEPTH and rst is low, with no combinational dependence on mdu_valid.
REQ-021 On a transfer with mdu_wa != 0, the entry SHALL be pushed at that edge; a transfer with mdu_wa == 0 SHALL be accepted and discarded.
REQ-022 Each edge, if wb_we=1 and wb_wa!=0, the rf_* outputs SHALL load {1, wb_wa, wb_wd}, and the FIFO SHALL NOT pop.
REQ-023 Otherwise, if the FIFO is non-empty, the rf_* outputs SHALL load {1, head.wa, head.wd}, and the head SHALL pop.
REQ-024 Otherwise rf_we SHALL load 0, while rf_wa and rf_wd hold their values.
REQ-025 wb_we=1 with wb_wa=0 SHALL be treated as no pipeline write, so the FIFO may drain that cycle.
REQ-026 Latency: a pipeline write SHALL appear on rf_* one edge after it is presented; a queued result SHALL appear no earlier than one edge after its push.
REQ-027 Push and pop in the same edge SHALL leave q_count unchanged; FIFO order SHALL be strictly first-in, first-out; pointers SHALL wrap modulo DEPTH.
REQ-028 mdu_issue=1 with mdu_issue_wa!=0 SHALL set pending[mdu_issue_wa].
REQ-029 A pop SHALL clear pending[head.wa]; if a set and a clear target the same register in the same edge, the set SHALL win.
REQ-030 Pipeline writes SHALL NOT modify pending.
REQ-031 q_busyN SHALL equal pending[q_raN] OR (rf_we AND rf_wa==q_raN), and SHALL be 0 when q_raN==0.
REQ-032 Continuous pipeline writes MAY starve the FIFO; when the FIFO is full, mdu_ready low SHALL be the only backpressure.

Reset
REQ-033 With rst high at an edge, the block SHALL set rf_we=0, rf_wa=0, rf_wd=0, q_count=0, pending=0 and read/write pointers=0.
REQ-034 While rst is high, mdu_ready SHALL be 0 and transfers SHALL be ignored.
REQ-035 Reset SHALL take effect mid-operation: queued entries SHALL be dropped, and no rf_we pulse SHALL follow for them.

Verification
REQ-036 Drive wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF for one cycle -> next edge rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; following edge rf_we=0.
REQ-037 Drive mdu_issue with wa=9, then later mdu_valid with wa=9, wd=0x1234 and no pipeline write -> q_busy1 (q_ra1=9) is 1 from the issue until rf_we drops; rf_wd=0x1234 one edge after the push.
REQ-038 Push two results (wa=3, then wa=4) while wb_we=1 to wa=7 continuously -> mdu_ready=0 at q_count=2, rf_wa stays 7; on releasing wb_we, rf_wa shows 3 then 4 on consecutive edges.
REQ-039 Drive mdu_valid with mdu_wa=0 and wb_we with wb_wa=0 -> no push, q_count unchanged, rf_we=0.
REQ-040 Same-cycle mdu_issue wa=6 and pop of head wa=6 -> pending[6] remains 1.
REQ-041 Assert rst with q_count=2 -> next edge q_count=0, rf_we=0, all q_busy=0; no later writes for the dropped entries.
